// File: rtl/i2s_rx.sv
// i2s_rx: I2S ADC deserialiser on clk_50; valid fires 4 cycles after the bclk rise carrying the right LSB.
// No backpressure by default; I2S_RX_HANDSHAKE_EN adds ready/overrun and holds valid until accepted.
module i2s_rx #(
  parameter int DATA_W   = 24,
  parameter int MAX_SLOT = 31
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              configured,
  input  logic              bclk,
  input  logic              adclrck,
  input  logic              adcdat,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid,
  output logic              frame_err
`ifdef I2S_RX_HANDSHAKE_EN
  ,
  input  logic              ready,
  output logic              overrun
`endif
);
  localparam int CNT_W = $clog2(MAX_SLOT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LIM = CNT_W'(MAX_SLOT);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAD} state_t;

  logic              r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic              r_lrck_s1, r_lrck_s2, r_dat_s1, r_dat_s2;
  logic              r_bit_tick, r_lrck_prev;
  state_t            r_state, w_state_nxt;
  logic              r_chan;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift, r_left_hold, r_left_data, r_right_data;
  logic              r_valid, r_frame_err;
  logic              w_lr_edge, w_start, w_chan_nxt, w_shift, w_count, w_done, w_err, w_commit;
  logic [DATA_W-1:0] w_shift_nxt;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_s3   <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
      r_bit_tick  <= 1'b0;
      r_lrck_prev <= 1'b0;
    end else begin
      r_bclk_s1   <= bclk;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_s3   <= r_bclk_s2;
      r_lrck_s1   <= adclrck;
      r_lrck_s2   <= r_lrck_s1;
      r_dat_s1    <= adcdat;
      r_dat_s2    <= r_dat_s1;
      // Registered edge detect; lrck/data stay stable until the next bclk fall.
      r_bit_tick  <= r_bclk_s2 & ~r_bclk_s3;
      if (r_bit_tick) r_lrck_prev <= r_lrck_s2;
    end
  end

  assign w_lr_edge   = r_bit_tick & (r_lrck_s2 != r_lrck_prev);
  assign w_shift_nxt = {r_shift[DATA_W-2:0], r_dat_s2};
  assign w_commit    = w_done & r_chan;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_chan_nxt  = ~r_chan;
    w_shift     = 1'b0;
    w_count     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (!configured) begin
      w_state_nxt = ST_IDLE;
    end else if (r_bit_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_lr_edge && !r_lrck_s2) begin
            w_state_nxt = ST_SHIFT;
            w_start     = 1'b1;
            w_chan_nxt  = 1'b0;
          end
        end
        ST_SHIFT: begin
          w_shift = 1'b1;
          // A word finishing on the edge tick completes and the tick becomes the next delay bit.
          if (r_bit_cnt == LAST_BIT) begin
            w_done = 1'b1;
            if (w_lr_edge) w_start     = 1'b1;
            else           w_state_nxt = ST_PAD;
          end else if (w_lr_edge) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PAD: begin
          if (w_lr_edge) begin
            w_start     = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else if (r_bit_cnt == SLOT_LIM) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_count = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_chan      <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_state_nxt == ST_IDLE) begin
        r_chan      <= 1'b0;
        r_bit_cnt   <= '0;
        r_shift     <= '0;
        r_left_hold <= '0;
      end else begin
        if (w_start) begin
          r_bit_cnt <= '0;
          r_chan    <= w_chan_nxt;
        end else if ((w_shift || w_count) && r_bit_cnt != SLOT_LIM) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_shift) r_shift <= w_shift_nxt;
        if (w_done && !r_chan) r_left_hold <= w_shift_nxt;
      end
    end
  end

`ifdef I2S_RX_HANDSHAKE_EN
  logic r_overrun;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_left_data  <= '0;
      r_right_data <= '0;
    end else if (w_commit && (!r_valid || ready)) begin
      r_valid      <= 1'b1;
      r_left_data  <= r_left_hold;
      r_right_data <= w_shift_nxt;
    end else if (w_commit) begin
      r_overrun    <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid      <= 1'b0;
    end
  end

  assign overrun = r_overrun;
`else
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_left_data  <= '0;
      r_right_data <= '0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_left_data  <= r_left_hold;
        r_right_data <= w_shift_nxt;
      end
    end
  end
`endif

  assign left_data  = r_left_data;
  assign right_data = r_right_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Receive half of the audio-codec serial link.
- Deserialises I2S ADC data (ADCDAT) from the codec into parallel 24-bit left/right samples at 48 kHz and hands them to the top-level DSP path.
- Runs entirely on clk_50. The codec-side bclk, adclrck and adcdat lines are treated as asynchronous and oversampled (about 19 clk_50 cycles per bclk period at 2.592 MHz).

Parameters:
- DATA_W, 24, bits captured per channel word, MSB first.
- MAX_SLOT, 31, maximum bclk periods per half-frame before a frame error; must be at least DATA_W+1.

Ports:
- clk_50  input  1  50 MHz system clock; only clock in the block.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- configured  input  1  high once I2C codec configuration has completed; 0 holds the block idle.
- bclk  input  1  codec bit clock, asynchronous to clk_50.
- adclrck  input  1  codec ADC word clock, asynchronous; 0 = left, 1 = right.
- adcdat  input  1  codec serial ADC data, asynchronous; changes on bclk falling edge.
- left_data  output  DATA_W  last complete left sample.
- right_data  output  DATA_W  last complete right sample.
- valid  output  1  one-cycle pulse when left_data/right_data update with a new stereo pair.
- frame_err  output  1  one-cycle pulse on a short or overlong half-frame.

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, FSM in IDLE; left_data=0, right_data=0, valid=0, frame_err=0. Same effect applies if reset is asserted mid-word; partial words are discarded.
- Input sync: bclk, adclrck and adcdat each pass through a 2-flop synchroniser, plus a third bclk stage for edge detection.
- bit_tick = synced bclk rising edge (s2=1, s3=0). All sampling of adclrck and adcdat happens only on bit_tick.
- lr_edge: sampled adclrck differs from its value at the previous bit_tick.
- Format: standard I2S.
  - The first bit_tick after an lr_edge is the delay bit and is ignored.
  - The next DATA_W ticks carry MSB to LSB.
  - Remaining ticks in the half-frame are ignored.
- FSM states:
  - IDLE: wait for configured=1 and an lr_edge to 0 (start of left). Then go to SHIFT with chan=L and bit_cnt=0; the aligning tick counts as the delay bit.
  - SHIFT: on each bit_tick, shift_reg <= {shift_reg[DATA_W-2:0], adcdat_s2} and bit_cnt+1. When bit_cnt reaches DATA_W, store the word into a holding register (left) or commit (right), then go to PAD.
  - PAD: ignore bits and count slots. On lr_edge, toggle chan, clear counters and go to SHIFT (the edge tick is the delay bit).
- Commit: on right-word completion, left_data <= held left word and right_data <= shift result; valid=1 for exactly one clk_50 cycle.
- Latency: valid asserts 4 clk_50 cycles after the raw bclk rising edge carrying the right-channel LSB (2 sync + 1 edge + 1 output register).
- Outputs hold between commits.
- Error conditions, each giving frame_err=1 for one cycle, discarding partial and held words, and returning to IDLE:
  - lr_edge seen in SHIFT before DATA_W bits are captured (short frame);
  - slot count exceeds MAX_SLOT without an lr_edge;
  - lr_edge to right while in IDLE-alignment is not an error; it is simply ignored.
- configured falling to 0 in any state: return to IDLE next cycle. Outputs keep their last values, no valid, no frame_err.
- Simultaneous events: if a word completes on the same bit_tick as an lr_edge (DATA_W+1 slots exactly), completion wins and the edge then starts the next channel with that tick as the delay bit.
- bit_cnt width is $clog2(MAX_SLOT+1); the slot counter saturates and never wraps.

Optional Feature:
- Macro I2S_RX_HANDSHAKE_EN.
- Defined: adds input ready (1 bit) and output overrun (1 bit, sticky, cleared only by reset).
  - valid becomes level: it rises on commit and stays high until a cycle with valid=1 and ready=1.
  - left_data and right_data stay frozen while valid=1.
  - A commit arriving while valid=1 and ready=0 drops the new pair, leaves the old pair intact and sets overrun=1.
  - A commit in the same cycle as the accepting handshake loads the new pair and valid stays 1.
- Undefined: no ready/overrun ports; valid is a single-cycle pulse and a commit always overwrites.

Test Plan:
- Reset then configured=1, codec model with a 386 ns bclk and 27 bclk per half-frame sending L=24'hA5A5A5 and R=24'h5A5A5A: first valid pulse gives left_data=A5A5A5 and right_data=5A5A5A, one pulse per 20.8 us frame, frame_err never asserts.
- Start the stream mid right channel: no valid until the first full L/R pair; the first pair decoded is correct.
- Short half-frame (lrck toggles after 20 data bits): frame_err pulses once, no valid for that frame, correct decode resumes on the next left frame.
- Hold lrck constant for 40 bclk: frame_err at slot 32; configured=0 mid-word gives no valid and no frame_err; reset=0 mid-word clears all outputs to 0 immediately.
- L=24'h800000, R=24'h000001 (MSB/LSB edges): exact values are reproduced; valid arrives 4 clk_50 cycles after the bclk rise of the R LSB.
- With I2S_RX_HANDSHAKE_EN and ready=0 for 2 frames: the first pair is held, overrun=1, and ready=1 then accepts the first pair.
